// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision matrix: report FSM state and
// the lexicographic (i,j) -> pair index mapping.
package collision_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    // Pairs (i,j) with i<j numbered row by row: (0,1)=0, (0,2)=1, ...
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/collision_pair_decode.sv
// Combinational pair-overlap decode: per-pair hit flags and the set of
// objects that take part in at least one enabled overlapping pair.
module collision_pair_decode
    import collision_pkg::*;
#(
    parameter int NUM_OBJ   = 4,
    parameter int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2
) (
    input  logic [NUM_OBJ-1:0]   draw_req_i,
    input  logic [NUM_PAIRS-1:0] pair_en_i,
    output logic [NUM_PAIRS-1:0] hit_o,
    output logic [NUM_OBJ-1:0]   obj_hit_o
);

    logic [NUM_OBJ-1:0] contrib   [NUM_PAIRS];
    logic [NUM_OBJ-1:0] vec_chain [NUM_PAIRS+1];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_OBJ - 1; gi++) begin : g_row
            for (gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_col
                localparam int P = pair_idx(gi, gj, NUM_OBJ);
                assign hit_o[P]   = draw_req_i[gi] & draw_req_i[gj] & pair_en_i[P];
                assign contrib[P] = {NUM_OBJ{hit_o[P]}} &
                                    ((NUM_OBJ'(1) << gi) | (NUM_OBJ'(1) << gj));
            end
        end

        // OR-reduce the per-pair object masks into one object vector.
        assign vec_chain[0] = '0;
        for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_or
            assign vec_chain[gi+1] = vec_chain[gi] | contrib[gi];
        end
    endgenerate

    assign obj_hit_o = vec_chain[NUM_PAIRS];

endmodule

// File: rtl/collision_matrix.sv
// Per-pixel object collision detector with per-frame sticky pair report,
// saturating hit-cycle counter and a valid/ack handshake with overrun flag.
module collision_matrix
    import collision_pkg::*;
#(
    parameter  int NUM_OBJ   = 4,
    parameter  int CNT_W     = 20,
    localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_OBJ-1:0]   drawReq,
    input  logic [NUM_PAIRS-1:0] pairEnable,
    input  logic                 startOfFrame,
    input  logic                 ack,
    output logic                 collide,
    output logic [NUM_OBJ-1:0]   collideVec,
    output logic                 frameValid,
    output logic [NUM_PAIRS-1:0] framePairs,
    output logic [CNT_W-1:0]     frameCount,
    output logic                 overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_PAIRS-1:0] hit;
    logic [NUM_OBJ-1:0]   obj_hit;
    logic                 any_hit;

    logic                 collide_q;
    logic [NUM_OBJ-1:0]   collide_vec_q;
    logic [NUM_PAIRS-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    state_e               state_q, state_d;
    logic [NUM_PAIRS-1:0] pairs_q, pairs_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overrun_q, overrun_d;

    logic [NUM_PAIRS-1:0] cap_pairs;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 new_rpt;

    collision_pair_decode #(
        .NUM_OBJ  (NUM_OBJ),
        .NUM_PAIRS(NUM_PAIRS)
    ) u_decode (
        .draw_req_i(drawReq),
        .pair_en_i (pairEnable),
        .hit_o     (hit),
        .obj_hit_o (obj_hit)
    );

    assign any_hit = |hit;

    always_comb begin
        // The frame boundary cycle's own hits belong to the closing frame.
        cap_pairs = acc_q | hit;
        cnt_inc   = (any_hit && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
        new_rpt   = startOfFrame && (cap_pairs != '0);
        acc_d     = startOfFrame ? '0 : cap_pairs;
        cnt_d     = startOfFrame ? '0 : cnt_inc;

        state_d   = state_q;
        pairs_d   = pairs_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (new_rpt) begin
                    state_d = PENDING;
                    pairs_d = cap_pairs;
                    count_d = cnt_inc;
                end
            end
            PENDING: begin
                if (new_rpt) begin
                    pairs_d = cap_pairs;
                    count_d = cnt_inc;
                    if (!ack) begin
                        overrun_d = 1'b1;
                    end
                end else if (ack) begin
                    state_d   = IDLE;
                    overrun_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collide_q     <= 1'b0;
            collide_vec_q <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            state_q       <= IDLE;
            pairs_q       <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
        end else begin
            collide_q     <= any_hit;
            collide_vec_q <= obj_hit;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            pairs_q       <= pairs_d;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
        end
    end

    assign collide    = collide_q;
    assign collideVec = collide_vec_q;
    assign frameValid = (state_q == PENDING);
    assign framePairs = pairs_q;
    assign frameCount = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_collision_matrix.sv
// Bench for collision_matrix: two instances (CNT_W=20 and CNT_W=4) share
// stimulus and are checked every cycle against a behavioural frame model.
module tb_collision_matrix;

    localparam int N      = 4;
    localparam int NP     = N * (N - 1) / 2;
    localparam int MAX_A  = (1 << 20) - 1;
    localparam int MAX_B  = (1 << 4) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  drawReq = '0;
    logic [NP-1:0] pairEnable = '1;
    logic          startOfFrame = 1'b0;
    logic          ack = 1'b0;

    logic          collide_a, collide_b;
    logic [N-1:0]  vec_a, vec_b;
    logic          valid_a, valid_b;
    logic [NP-1:0] pairs_a, pairs_b;
    logic [19:0]   count_a;
    logic [3:0]    count_b;
    logic          overrun_a, overrun_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    collision_matrix #(.NUM_OBJ(N), .CNT_W(20)) dut_a (
        .clk(clk), .reset(reset), .drawReq(drawReq), .pairEnable(pairEnable),
        .startOfFrame(startOfFrame), .ack(ack),
        .collide(collide_a), .collideVec(vec_a), .frameValid(valid_a),
        .framePairs(pairs_a), .frameCount(count_a), .overrun(overrun_a)
    );

    collision_matrix #(.NUM_OBJ(N), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .drawReq(drawReq), .pairEnable(pairEnable),
        .startOfFrame(startOfFrame), .ack(ack),
        .collide(collide_b), .collideVec(vec_b), .frameValid(valid_b),
        .framePairs(pairs_b), .frameCount(count_b), .overrun(overrun_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_collide = 1'b0;
    logic [N-1:0]  m_vec = '0;
    logic [NP-1:0] m_acc = '0;
    int            m_raw = 0;
    logic          m_valid = 1'b0;
    logic [NP-1:0] m_pairs = '0;
    int            m_cnt = 0;
    logic          m_overrun = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [NP-1:0] hits;
        logic [N-1:0]  objs;
        int p;
        if (reset) begin
            m_collide = 0; m_vec = '0; m_acc = '0; m_raw = 0;
            m_valid = 0; m_pairs = '0; m_cnt = 0; m_overrun = 0;
        end else begin
            hits = '0; objs = '0; p = 0;
            for (int i = 0; i < N; i++) begin
                for (int j = i + 1; j < N; j++) begin
                    if (drawReq[i] && drawReq[j] && pairEnable[p]) begin
                        hits[p] = 1'b1; objs[i] = 1'b1; objs[j] = 1'b1;
                    end
                    p++;
                end
            end
            m_collide = (hits != '0);
            m_vec     = objs;
            m_acc     = m_acc | hits;
            if (hits != '0) m_raw++;
            if (startOfFrame) begin
                if (m_acc != '0) begin
                    if (m_valid && !ack) m_overrun = 1'b1;
                    m_valid = 1'b1;
                    m_pairs = m_acc;
                    m_cnt   = m_raw;
                end else if (ack) begin
                    m_valid = 1'b0; m_overrun = 1'b0;
                end
                m_acc = '0;
                m_raw = 0;
            end else if (ack) begin
                m_valid = 1'b0; m_overrun = 1'b0;
            end
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("collide_a", 32'(collide_a), 32'(m_collide));
        chk("collide_b", 32'(collide_b), 32'(m_collide));
        chk("vec_a", 32'(vec_a), 32'(m_vec));
        chk("vec_b", 32'(vec_b), 32'(m_vec));
        chk("valid_a", 32'(valid_a), 32'(m_valid));
        chk("valid_b", 32'(valid_b), 32'(m_valid));
        chk("pairs_a", 32'(pairs_a), 32'(m_pairs));
        chk("pairs_b", 32'(pairs_b), 32'(m_pairs));
        chk("count_a", 32'(count_a), 32'(sat(m_cnt, MAX_A)));
        chk("count_b", 32'(count_b), 32'(sat(m_cnt, MAX_B)));
        chk("overrun_a", 32'(overrun_a), 32'(m_overrun));
        chk("overrun_b", 32'(overrun_b), 32'(m_overrun));
    end

    // Drive one cycle, then settle #1 past the edge so outputs reflect it.
    task automatic cyc(input logic [N-1:0] dr, input logic [NP-1:0] en,
                       input logic sof, input logic ak);
        drawReq = dr; pairEnable = en; startOfFrame = sof; ack = ak;
        @(posedge clk);
        #1;
        drawReq = '0; startOfFrame = 1'b0; ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_zero_a"}, {collide_a, vec_a, valid_a, pairs_a, count_a[19:0], overrun_a}, 32'h0);
        chk({tag, "_zero_b"}, {collide_b, vec_b, valid_b, pairs_b, count_b, overrun_b}, 32'h0);
    endtask

    localparam logic [NP-1:0] ALL = '1;

    initial begin
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic pair detection, latency 1
        cyc(4'b0011, ALL, 0, 0);
        chk("lit_collide_0011", 32'(collide_a), 32'd1);
        chk("lit_vec_0011", 32'(vec_a), 32'b0011);
        $display("txn: drawReq=0011 collide=%0b vec=%b", collide_a, vec_a);
        cyc(4'b0001, ALL, 0, 0);
        chk("lit_collide_0001", 32'(collide_a), 32'd0);
        cyc(4'b0000, ALL, 1, 0);
        chk("lit_pairs_first", 32'(pairs_a), 32'b000001);
        cyc(4'b0000, ALL, 0, 1);

        // Mixed frame: 3x 0101, 2x 1110
        repeat (3) cyc(4'b0101, ALL, 0, 0);
        repeat (2) cyc(4'b1110, ALL, 0, 0);
        cyc(4'b0000, ALL, 1, 0);
        chk("lit_valid_mix", 32'(valid_a), 32'd1);
        chk("lit_pairs_mix", 32'(pairs_a), 32'b111010);
        chk("lit_count_mix", 32'(count_a), 32'd5);
        $display("txn: frame pairs=%b count=%0d", pairs_a, count_a);
        cyc(4'b0000, ALL, 0, 1);

        // Disabled pair never reports
        repeat (10) cyc(4'b0011, 6'b111110, 0, 0);
        chk("lit_collide_masked", 32'(collide_a), 32'd0);
        cyc(4'b0000, 6'b111110, 1, 0);
        chk("lit_valid_masked", 32'(valid_a), 32'd0);

        // Overrun: two frames without ack
        cyc(4'b0011, ALL, 0, 0);
        cyc(4'b0000, ALL, 1, 0);
        cyc(4'b1100, ALL, 0, 0);
        cyc(4'b0000, ALL, 1, 0);
        chk("lit_pairs_overrun", 32'(pairs_a), 32'b100000);
        chk("lit_overrun_set", 32'(overrun_a), 32'd1);
        $display("txn: overrun=%0b pairs=%b", overrun_a, pairs_a);
        cyc(4'b0000, ALL, 0, 1);
        chk("lit_valid_acked", 32'(valid_a), 32'd0);
        chk("lit_overrun_clr", 32'(overrun_a), 32'd0);

        // Simultaneous ack + new frame; boundary cycle's hit is captured
        cyc(4'b0011, ALL, 0, 0);
        cyc(4'b0000, ALL, 1, 0);
        cyc(4'b0011, ALL, 0, 0);
        cyc(4'b0101, ALL, 1, 1);
        chk("lit_pairs_ackload", 32'(pairs_a), 32'b000011);
        chk("lit_count_ackload", 32'(count_a), 32'd2);
        chk("lit_overrun_ackload", 32'(overrun_a), 32'd0);
        cyc(4'b0000, ALL, 0, 1);

        // Saturation
        repeat (20) cyc(4'b0011, ALL, 0, 0);
        cyc(4'b0000, ALL, 1, 0);
        chk("lit_count_sat_b", 32'(count_b), 32'd15);
        chk("lit_count_a20", 32'(count_a), 32'd20);
        $display("txn: saturate count_a=%0d count_b=%0d", count_a, count_b);
        cyc(4'b0000, ALL, 0, 1);

        // Reset mid-frame
        repeat (3) cyc(4'b0011, ALL, 0, 0);
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(4'b0000, ALL, 1, 0);
        chk("lit_valid_after_reset", 32'(valid_a), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            logic [N-1:0]  dr;
            logic [NP-1:0] en;
            dr = N'($urandom);
            en = ($urandom_range(0, 3) == 0) ? NP'($urandom) : ALL;
            cyc(dr, en, ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0));
            if (valid_a && ($urandom_range(0, 63) == 0))
                $display("txn: rnd t=%0d pairs=%b count=%0d overrun=%0b", t, pairs_a, count_a, overrun_a);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
